// File: rtl/uart_arbiter.sv
// uart_arbiter
//   Shares one UART register port between three CPU cores. One register
//   transaction (write strobe, or read strobe plus data capture) is in
//   flight at a time. Grants rotate round-robin so that no core starves.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   cpuN_req/we/adr/dat_o    per-core request (level), direction, address, write data
//   cpuN_ack                 one-cycle completion pulse to the owning core
//   cpuN_dat_i               per-core read data, held until that core's next read
//   uart_rd/uart_wr          one-cycle strobes to the UART
//   uart_addr/uart_din       UART address / write data, held outside ISSUE
//   uart_dout                UART read data, valid RD_LAT cycles after uart_rd
//   cpu_uart_num             current owner, 2'b11 when idle
//
// FSM states
//   state  | meaning
//   IDLE   | no transaction; arbitrate among all requesters
//   ISSUE  | one-cycle uart_wr or uart_rd strobe from the latched request
//   WAIT   | RD_LAT cycles of read latency; capture uart_dout on the last one
//   DONE   | ack to owner; arbitrate among the other cores for a direct reissue
module uart_arbiter #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu0_req,
    input  logic          cpu0_we,
    input  logic [1:0]    cpu0_adr,
    input  logic [DW-1:0] cpu0_dat_o,
    output logic          cpu0_ack,
    output logic [DW-1:0] cpu0_dat_i,
    input  logic          cpu1_req,
    input  logic          cpu1_we,
    input  logic [1:0]    cpu1_adr,
    input  logic [DW-1:0] cpu1_dat_o,
    output logic          cpu1_ack,
    output logic [DW-1:0] cpu1_dat_i,
    input  logic          cpu2_req,
    input  logic          cpu2_we,
    input  logic [1:0]    cpu2_adr,
    input  logic [DW-1:0] cpu2_dat_o,
    output logic          cpu2_ack,
    output logic [DW-1:0] cpu2_dat_i,
    output logic          uart_rd,
    output logic          uart_wr,
    output logic [1:0]    uart_addr,
    output logic [DW-1:0] uart_din,
    input  logic [DW-1:0] uart_dout,
    output logic [1:0]    cpu_uart_num
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic          lat_we;
    logic [CW-1:0] wait_cnt;

    logic [2:0]    req_v;
    logic [2:0]    req_m;
    logic [1:0]    cand0, cand1, cand2;
    logic          arb_valid;
    logic [1:0]    arb_win;
    logic          grant;
    logic          sel_we;
    logic [1:0]    sel_adr;
    logic [DW-1:0] sel_dat;
    logic          wait_last;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign req_v = {cpu2_req, cpu1_req, cpu0_req};

    // In DONE the finishing owner is masked so the other cores get a turn
    // before its (possibly still high) req can be seen again.
    always_comb begin
        req_m = req_v;
        if (state == S_DONE) begin
            req_m = req_v & ~(3'b001 << owner);
        end
        cand0     = ptr;
        cand1     = inc3(ptr);
        cand2     = inc3(cand1);
        arb_valid = 1'b1;
        arb_win   = 2'd0;
        if (req_m[cand0]) begin
            arb_win = cand0;
        end else if (req_m[cand1]) begin
            arb_win = cand1;
        end else if (req_m[cand2]) begin
            arb_win = cand2;
        end else begin
            arb_valid = 1'b0;
        end
    end

    assign grant     = arb_valid && ((state == S_IDLE) || (state == S_DONE));
    assign wait_last = (state == S_WAIT) && (wait_cnt == '0);

    always_comb begin
        sel_we  = cpu0_we;
        sel_adr = cpu0_adr;
        sel_dat = cpu0_dat_o;
        case (arb_win)
            2'd1: begin
                sel_we  = cpu1_we;
                sel_adr = cpu1_adr;
                sel_dat = cpu1_dat_o;
            end
            2'd2: begin
                sel_we  = cpu2_we;
                sel_adr = cpu2_adr;
                sel_dat = cpu2_dat_o;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = lat_we ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = arb_valid ? S_ISSUE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant latch, latency timer and read-data capture. uart_addr/uart_din
    // are loaded on the grant edge, so they change only as ISSUE begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= 2'd0;
            owner      <= 2'd0;
            lat_we     <= 1'b0;
            uart_addr  <= 2'd0;
            uart_din   <= '0;
            wait_cnt   <= '0;
            cpu0_dat_i <= '0;
            cpu1_dat_i <= '0;
            cpu2_dat_i <= '0;
        end else begin
            if (grant) begin
                owner     <= arb_win;
                lat_we    <= sel_we;
                uart_addr <= sel_adr;
                uart_din  <= sel_dat;
                ptr       <= inc3(arb_win);
            end
            if (state == S_ISSUE) begin
                wait_cnt <= CW'(RD_LAT - 1);
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (wait_last) begin
                case (owner)
                    2'd0:    cpu0_dat_i <= uart_dout;
                    2'd1:    cpu1_dat_i <= uart_dout;
                    2'd2:    cpu2_dat_i <= uart_dout;
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        uart_wr      = (state == S_ISSUE) && lat_we;
        uart_rd      = (state == S_ISSUE) && !lat_we;
        cpu0_ack     = (state == S_DONE) && (owner == 2'd0);
        cpu1_ack     = (state == S_DONE) && (owner == 2'd1);
        cpu2_ack     = (state == S_DONE) && (owner == 2'd2);
        cpu_uart_num = (state == S_IDLE) ? 2'b11 : owner;
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter with RD_LAT=2: a scoreboard of expected UART
// transactions (compared at each strobe and each ack), a table of single
// transactions, and hand-written reset/contention/fairness/abort sequences.
module tb_uart_arbiter;

    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [2:0]    we;
    logic [1:0]    adr [3];
    logic [DW-1:0] dat [3];
    logic          cpu0_ack, cpu1_ack, cpu2_ack;
    logic [DW-1:0] cpu0_dat_i, cpu1_dat_i, cpu2_dat_i;
    logic          uart_rd, uart_wr;
    logic [1:0]    uart_addr;
    logic [DW-1:0] uart_din;
    logic [DW-1:0] uart_dout;
    logic [1:0]    cpu_uart_num;
    logic [2:0]    ackv;

    always #5 clk = ~clk;

    uart_arbiter #(.DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu0_req(req[0]), .cpu0_we(we[0]), .cpu0_adr(adr[0]), .cpu0_dat_o(dat[0]),
        .cpu0_ack(cpu0_ack), .cpu0_dat_i(cpu0_dat_i),
        .cpu1_req(req[1]), .cpu1_we(we[1]), .cpu1_adr(adr[1]), .cpu1_dat_o(dat[1]),
        .cpu1_ack(cpu1_ack), .cpu1_dat_i(cpu1_dat_i),
        .cpu2_req(req[2]), .cpu2_we(we[2]), .cpu2_adr(adr[2]), .cpu2_dat_o(dat[2]),
        .cpu2_ack(cpu2_ack), .cpu2_dat_i(cpu2_dat_i),
        .uart_rd(uart_rd), .uart_wr(uart_wr), .uart_addr(uart_addr),
        .uart_din(uart_din), .uart_dout(uart_dout), .cpu_uart_num(cpu_uart_num)
    );

    assign ackv = {cpu2_ack, cpu1_ack, cpu0_ack};

    // UART model: read data is valid only in the single cycle RD_LAT cycles
    // after the strobe, so early or late capture shows up as 8'hEE.
    logic [DW-1:0] rom [4];
    logic [RD_LAT:1] rd_pipe;
    logic [1:0]      rd_adr;

    initial begin
        rom[0] = 8'h3C; rom[1] = 8'hC3; rom[2] = 8'h81; rom[3] = 8'h7E;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pipe <= '0;
            rd_adr  <= 2'd0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-1:1], uart_rd};
            if (uart_rd) rd_adr <= uart_addr;
        end
    end

    assign uart_dout = rd_pipe[RD_LAT] ? rom[rd_adr] : 8'hEE;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int            core;
        logic          we;
        logic [1:0]    adr;
        logic [DW-1:0] dat;
    } txn_t;

    txn_t sb_q[$];
    txn_t ack_q[$];
    txn_t mon_e;
    txn_t ack_e;
    logic [DW-1:0] exp_dat_i [3];

    function automatic txn_t mk(input int c, input logic w, input logic [1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.core = c; t.we = w; t.adr = a; t.dat = d;
        return t;
    endfunction

    // Monitor: every strobe must match the next expected transaction, every
    // ack must match the transaction that was strobed before it.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (uart_wr || uart_rd) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", {uart_wr, uart_rd, cpu_uart_num}, 4'b0011);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("strobe", {cpu_uart_num, uart_wr, uart_rd, uart_addr, uart_din},
                        {2'(mon_e.core), mon_e.we, ~mon_e.we, mon_e.adr, mon_e.dat});
                    ack_q.push_back(mon_e);
                end
            end
            if (ackv != 3'b000) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", ackv, 3'b000);
                end else begin
                    ack_e = ack_q.pop_front();
                    chk("ack_owner", {ackv, cpu_uart_num}, {3'(3'b001 << ack_e.core), 2'(ack_e.core)});
                    if (!ack_e.we) begin
                        case (ack_e.core)
                            0:       chk("ack_rdata0", cpu0_dat_i, rom[ack_e.adr]);
                            1:       chk("ack_rdata1", cpu1_dat_i, rom[ack_e.adr]);
                            default: chk("ack_rdata2", cpu2_dat_i, rom[ack_e.adr]);
                        endcase
                    end
                end
            end
        end
    end

    typedef struct {
        int            core;
        logic          we;
        logic [1:0]    adr;
        logic [DW-1:0] dat;
        int            lat;
    } vec_t;

    vec_t       vecs [7];
    logic [5:0] cont_exp [8];

    task automatic do_reset();
        rst = 1'b0;
        req = 3'b000;
        sb_q.delete();
        ack_q.delete();
        for (int k = 0; k < 3; k++) exp_dat_i[k] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        // single transactions: core, we, adr, dat, cycles from req to ack
        vecs[0] = '{1, 1'b1, 2'd2, 8'hA5, 2};
        vecs[1] = '{2, 1'b0, 2'd0, 8'h00, 2 + RD_LAT};
        vecs[2] = '{0, 1'b0, 2'd1, 8'h12, 2 + RD_LAT};
        vecs[3] = '{0, 1'b1, 2'd3, 8'h5A, 2};
        vecs[4] = '{1, 1'b0, 2'd2, 8'h34, 2 + RD_LAT};
        vecs[5] = '{2, 1'b1, 2'd1, 8'hFF, 2};
        vecs[6] = '{2, 1'b0, 2'd3, 8'h56, 2 + RD_LAT};
        // contention, per cycle: {uart_wr, ack[2:0], cpu_uart_num}
        cont_exp[0] = 6'b0_000_11; cont_exp[1] = 6'b1_000_00;
        cont_exp[2] = 6'b0_001_00; cont_exp[3] = 6'b1_000_01;
        cont_exp[4] = 6'b0_010_01; cont_exp[5] = 6'b1_000_10;
        cont_exp[6] = 6'b0_100_10; cont_exp[7] = 6'b0_000_11;

        // Reset held with all cores requesting writes
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            we[k]  = 1'b1;
            adr[k] = 2'(k);
            dat[k] = 8'h10 + 8'(k);
            exp_dat_i[k] = '0;
        end
        req = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {uart_wr, uart_rd, ackv, cpu_uart_num}, 7'b00_000_11);
        chk("rst_bus", {uart_addr, uart_din}, '0);
        chk("rst_dat_i", {cpu2_dat_i, cpu1_dat_i, cpu0_dat_i}, '0);

        // Release: grants 0,1,2 strobed on cycles 1,3,5 and acked on 2,4,6
        for (int k = 0; k < 3; k++) sb_q.push_back(mk(k, 1'b1, 2'(k), 8'h10 + 8'(k)));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [2:0] seen;
            @(negedge clk);
            chk($sformatf("contend_c%0d", c), {uart_wr, ackv, cpu_uart_num}, cont_exp[c]);
            seen = ackv;
            @(posedge clk); #1;
            req = req & ~seen;
        end
        req = 3'b000;

        // Table of single transactions
        for (int v = 0; v < 7; v++) begin
            int got;
            int cr;
            cr  = vecs[v].core;
            got = -1;
            @(posedge clk); #1;
            we[cr]  = vecs[v].we;
            adr[cr] = vecs[v].adr;
            dat[cr] = vecs[v].dat;
            req[cr] = 1'b1;
            sb_q.push_back(mk(cr, vecs[v].we, vecs[v].adr, vecs[v].dat));
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    chk($sformatf("v%0d_issue", v), {cpu_uart_num, uart_wr, uart_rd},
                        {2'(cr), vecs[v].we, ~vecs[v].we});
                end
                if (ackv[cr]) begin
                    got = c;
                    break;
                end
                @(posedge clk); #1;
                if (c == 1) begin
                    // inputs were latched at grant; disturbing them now must not matter
                    adr[cr] = ~vecs[v].adr;
                    dat[cr] = ~vecs[v].dat;
                    we[cr]  = ~vecs[v].we;
                end
            end
            chk($sformatf("v%0d_latency", v), got, vecs[v].lat);
            if (!vecs[v].we) exp_dat_i[cr] = rom[vecs[v].adr];
            chk($sformatf("v%0d_dat_i", v), {cpu2_dat_i, cpu1_dat_i, cpu0_dat_i},
                {exp_dat_i[2], exp_dat_i[1], exp_dat_i[0]});
            @(posedge clk); #1;
            req[cr] = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_idle_hold", v), {cpu_uart_num, uart_addr, uart_din, uart_wr, uart_rd},
                {2'b11, vecs[v].adr, vecs[v].dat, 2'b00});
        end

        // Reset during the final WAIT cycle of a cpu2 read
        begin
            int acks;
            acks = 0;
            @(posedge clk); #1;
            we[2] = 1'b0; adr[2] = 2'd0; dat[2] = 8'h11; req[2] = 1'b1;
            sb_q.push_back(mk(2, 1'b0, 2'd0, 8'h11));
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("abort_in_wait", {ackv, cpu_uart_num, uart_wr, uart_rd}, {3'b000, 2'd2, 2'b00});
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk("abort_ctrl", {uart_wr, uart_rd, ackv, cpu_uart_num}, 7'b00_000_11);
            chk("abort_bus", {uart_addr, uart_din}, '0);
            chk("abort_dat_i", {cpu2_dat_i, cpu1_dat_i, cpu0_dat_i}, '0);
            req = 3'b000;
            ack_q.delete();
            sb_q.delete();
            @(posedge clk); #1;
            rst = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (ackv != 3'b000) acks++;
            end
            chk("abort_no_ack", acks, 0);
            chk("abort_dat_i_after", {cpu2_dat_i, cpu1_dat_i, cpu0_dat_i}, '0);
        end

        // Fairness: cpu0 and cpu1 both keep requesting; grants must alternate
        do_reset();
        begin
            int n_str;
            int last;
            n_str = 0;
            last  = -1;
            we[0] = 1'b1; adr[0] = 2'd1; dat[0] = 8'hC0;
            we[1] = 1'b1; adr[1] = 2'd2; dat[1] = 8'hC1;
            for (int i = 0; i < 6; i++) begin
                sb_q.push_back(mk(i % 2, 1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, (i % 2 == 0) ? 8'hC0 : 8'hC1));
            end
            @(posedge clk); #1;
            req = 3'b011;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (uart_wr) begin
                    n_str++;
                    last = c;
                end
                if (n_str == 6) break;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            req = 3'b000;
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("fair_strobes", n_str, 6);
            chk("fair_last_cycle", last, 11);
            chk("fair_drained", {sb_q.size(), ack_q.size()}, '0);
            chk("fair_idle", cpu_uart_num, 2'b11);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_arbiter.md
# uart_arbiter

Arbitrates three CPU cores for a single shared UART register port. It sequences one register transaction at a time, either a write strobe or a read strobe with capture. Grants rotate round-robin, so no core starves. The block sits between the per-core UART bus outputs and the UART core. It replaces static selection with request/acknowledge sharing.

## Interface
Parameters:
- DW, 8, UART data width.
- RD_LAT, 1, cycles from the uart_rd strobe to valid uart_dout. Must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low: rst=0 clears all state immediately.
- cpuN_req  in  1  (N=0,1,2) transaction request, level. Held until cpuN_ack.
- cpuN_we  in  1  1=write, 0=read. Stable while req=1.
- cpuN_adr  in  2  UART register address. Stable while req=1.
- cpuN_dat_o  in  DW  write data. Stable while req=1.
- cpuN_ack  out  1  one-cycle completion pulse.
- cpuN_dat_i  out  DW  read data. Registered; updated only on that core's read completion, otherwise held.
- uart_rd  out  1  read strobe to the UART.
- uart_wr  out  1  write strobe to the UART.
- uart_addr  out  2  UART register address.
- uart_din  out  DW  write data to the UART.
- uart_dout  in  DW  read data from the UART.
- cpu_uart_num  out  2  current owner (0..2); 2'b11 when no transaction is in flight.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If any req=1, pick a winner, latch owner, we, adr and dat, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (1 cycle):
  - Drive uart_addr and uart_din from the latched values, from registers.
  - Assert uart_wr if we=1, else uart_rd.
  - Next state: WAIT for a read, DONE for a write.
- **WAIT** (exactly RD_LAT cycles, counter-driven): on the final WAIT edge, capture uart_dout into cpu<owner>_dat_i, then go to DONE.
- **DONE** (1 cycle):
  - cpu<owner>_ack=1.
  - Arbitrate among the non-owner requesters only (the owner's req is masked in this cycle).
  - If a winner exists, latch it and go straight to ISSUE; else go to IDLE.
- **Round-robin arbitration:**
  - A pointer ptr∈{0,1,2}, reset to 0.
  - Search order is ptr, ptr+1, ptr+2 (mod 3); the first requester found wins.
  - On every grant, ptr ← winner+1 (mod 3).
- **Req handling after ack:** a core must drop req on the edge ending its ack cycle. A req still high when next sampled in IDLE or DONE counts as a new request.
- **Strobe and bus values:**
  - uart_rd and uart_wr are never both 1.
  - Each is high only in ISSUE, for exactly one cycle per transaction.
  - uart_addr and uart_din hold their last value outside ISSUE.
- cpu_uart_num = owner in ISSUE, WAIT and DONE; 2'b11 in IDLE.
- Input changes during an owned transaction have no effect (inputs are latched at grant).

## Timing
- **Reset values:** state=IDLE, ptr=0, all ack/uart_rd/uart_wr=0, uart_addr=0, uart_din=0, all cpuN_dat_i=0, cpu_uart_num=2'b11.
- **Reset mid-operation:** the transaction is abandoned immediately. No ack follows reset release.
- **Write latency:** req rises in cycle 0, uart_wr in cycle 1, ack in cycle 2.
- **Read latency:**
  - uart_rd in cycle 1, WAIT in cycles 2..1+RD_LAT, ack in cycle 2+RD_LAT.
  - dat_i becomes valid in the ack cycle and stays until that core's next read completion.
- **Throughput:** back-to-back transactions from different cores give one strobe every 2 cycles for writes and every 2+RD_LAT cycles for reads (DONE→ISSUE).
- **Single core repeating:** minimum 3 cycles per write (DONE→IDLE→ISSUE).
- **Simultaneous requests:** resolved purely by ptr. A waiting core is granted within 2 other transactions.

## Test plan
- **Reset:** hold rst=0 with all reqs high → all outputs at reset values, no strobes. Release → first grant goes to cpu0 (ptr=0).
- **Single write:** cpu1 req, we=1, adr=2, dat=8'hA5 → uart_wr=1 with addr=2, din=A5 in cycle 1; cpu1_ack in cycle 2; cpu_uart_num=1 in cycles 1-2, then 3.
- **Single read with RD_LAT=2:** cpu2 reads adr=0 and the UART returns 8'h3C → uart_rd in cycle 1, cpu2_ack in cycle 4, cpu2_dat_i=3C held thereafter; cpu0_dat_i and cpu1_dat_i unchanged.
- **Contention:** all three request writes in the same cycle → wr strobes in grant order 0, 1, 2 on cycles 1, 3, 5; acks on cycles 2, 4, 6.
- **Fairness:** cpu0 re-requests immediately after every ack while cpu1 requests continuously → grants alternate 0, 1, 0, 1; cpu1 is never skipped.
- **Reset mid-read:** assert rst=0 during WAIT → immediate return to reset values. After release, no ack and no dat_i update occur for the aborted read.
